// File: rtl/alu_mul_seq.sv
// Unsigned shift-and-add multiplier that borrows the shared ALU adder; done pulses (msb(op_b)+2) cycles after start.
// No backpressure: start is accepted only when idle, and a start while busy is dropped.
module alu_mul_seq #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [width-1:0] op_a,
  input  logic [width-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] product,
  output logic             ovf,
  output logic             alu_req,
  output logic [width-1:0] alu_a,
  output logic [width-1:0] alu_b,
  output logic [1:0]       alu_control,
  input  logic [width-1:0] alu_result,
  input  logic [3:0]       alu_flags
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [width-1:0] acc_q, acc_d;
  logic [width-1:0] mcand_q, mcand_d;
  logic [width-1:0] mplier_q, mplier_d;
  logic [width-1:0] product_q, product_d;
  logic             ovf_q, ovf_d;
  logic             last_bit;

  // Only the carry flag matters; n, z and v are deliberately dropped.
  logic unused_flags;
  assign unused_flags = ^{alu_flags[3:2], alu_flags[0]};

  assign last_bit = (mplier_q[width-1:1] == '0);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    ovf_d     = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          ovf_d    = 1'b0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (mplier_q[0]) begin
          acc_d = alu_result;
          ovf_d = ovf_q | alu_flags[1];
        end
        // A multiplicand bit shifted out still matters if any higher multiplier bit is set.
        ovf_d    = ovf_d | (mcand_q[width-1] & ~last_bit);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (last_bit) begin
          product_d = mplier_q[0] ? alu_result : acc_q;
          state_d   = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign alu_req     = (state_q == S_RUN);
  assign alu_a       = acc_q;
  assign alu_b       = mcand_q;
  assign alu_control = 2'b00;
  assign product     = product_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: external adder ALU model, arithmetic reference model checked every cycle,
// plus directed multiplies with hand-computed product, overflow and latency.
module tb_alu_mul_seq;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  op_a = '0, op_b = '0;
  logic          busy, done, ovf, alu_req;
  logic [W-1:0]  product, alu_a, alu_b, alu_result;
  logic [1:0]    alu_control;
  logic [3:0]    alu_flags;
  logic [W:0]    alu_sum;

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  // Shared ALU in add mode: flags {n,z,c,v}.
  assign alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_result = alu_sum[W-1:0];
  assign alu_flags  = {alu_result[W-1], (alu_result == '0), alu_sum[W],
                       (alu_a[W-1] == alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1])};

  alu_mul_seq #(.width(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product), .ovf(ovf),
    .alu_req(alu_req), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_flags(alu_flags)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int run_cycles(input logic [W-1:0] b);
    int r = 1;
    for (int i = 0; i < W; i++) if (b[i]) r = i + 1;
    return r;
  endfunction

  // Reference model: an accepted request occupies m_runs RUN cycles then one DONE cycle.
  bit           m_busy = 1'b0;
  int           m_runs = 0;
  int           m_left = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_prod = '0;
  logic         m_ovf = 1'b0;

  always @(posedge clk) begin
    logic [63:0] full;
    full = 64'(m_a) * 64'(m_b);
    if (reset) begin
      m_busy <= 1'b0; m_left <= 0; m_runs <= 0; m_prod <= '0; m_ovf <= 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1;
        m_runs <= run_cycles(op_b);
        m_left <= run_cycles(op_b);
        m_a    <= op_a;
        m_b    <= op_b;
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_prod <= full[W-1:0];
        m_ovf  <= |full[63:W];
      end
    end else begin
      m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      logic        exp_req;
      logic [63:0] mask, part, sh;
      int          k;
      exp_req = m_busy && (m_left != 0);
      chk("busy", busy, m_busy);
      chk("done", done, m_busy && (m_left == 0));
      chk("alu_req", alu_req, exp_req);
      chk("alu_control", alu_control, 2'b00);
      chk("product", product, m_prod);
      if (!exp_req) chk("ovf", ovf, m_ovf);
      if (exp_req) begin
        k    = m_runs - m_left;
        mask = (64'd1 << k) - 64'd1;
        part = 64'(m_a) * (64'(m_b) & mask);
        sh   = 64'(m_a) << k;
        chk("alu_a_acc", alu_a, part[W-1:0]);
        chk("alu_b_mcand", alu_b, sh[W-1:0]);
      end
    end
  end

  task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    start = 1'b1; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ep, input logic eo, input int elat);
    int n = 0;
    int reqs = 0;
    bit seen = 1'b0;
    pulse_start(a, b);
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (alu_req) reqs++;
      if (done) begin seen = 1'b1; n = i; end
    end
    chk("done_latency", n, elat);
    chk("lit_product", product, ep);
    chk("lit_ovf", ovf, eo);
    chk("alu_req_cycles", reqs, elat - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    armed = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_alu_req", alu_req, 0);
    chk("rst_product", product, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);

    run_mul(32'd7, 32'd6, 32'd42, 1'b0, 4);
    run_mul(32'h1234_5678, 32'd0, 32'd0, 1'b0, 2);
    run_mul(32'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    run_mul(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1, 3);
    run_mul(32'h8000_0000, 32'd3, 32'h8000_0000, 1'b1, 3);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 33);
    run_mul(32'h0001_0000, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 17);

    // Starts during RUN and on the done cycle must both be dropped.
    pulse_start(32'd7, 32'd6);
    @(posedge clk); #1;
    start = 1'b1; op_a = 32'd3; op_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      chk("ign_done_seen", seen, 1);
    end
    start = 1'b1; op_a = 32'd9; op_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("ign_busy", busy, 0);
      chk("ign_product", product, 32'd42);
    end
    run_mul(32'd5, 32'd5, 32'd25, 1'b0, 4);

    // Reset mid-RUN abandons the multiply and clears the result.
    pulse_start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_busy", busy, 0);
    chk("mrst_alu_req", alu_req, 0);
    chk("mrst_product", product, 0);
    chk("mrst_ovf", ovf, 0);
    chk("mrst_done", done, 0);
    repeat (36) @(negedge clk);
    run_mul(32'd3, 32'd5, 32'd15, 1'b0, 4);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle unsigned shift-and-add multiplier sequencer. It borrows the processor's shared 2-bit-control ALU (adder, op 2'b00) to compute a width-bit product.
- Sits beside the datapath. While busy it asserts alu_req, and the ALU input muxes route alu_a/alu_b/alu_control from this block instead of the register file and decoder.
- The ALU stays combinational and external; this block owns the sequencing, operand shifting and overflow tracking.

Parameters:
- width, 32, operand/product width; must match the ALU width.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a multiply; sampled only in IDLE
- op_a  input  width  multiplicand, sampled with start
- op_b  input  width  multiplier, sampled with start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse when product is valid
- product  output  width  low width bits of op_a*op_b; held until next accepted start
- ovf  output  1  set if the true product exceeds width bits; held with product
- alu_req  output  1  high in RUN; datapath grants the ALU to this block
- alu_a  output  width  ALU operand a (accumulator register)
- alu_b  output  width  ALU operand b (shifted multiplicand register)
- alu_control  output  2  constant 2'b00 (add)
- alu_result  input  width  ALU result, combinational from alu_a/alu_b
- alu_flags  input  4  ALU flags {n,z,c,v}; only c (bit 1) is used

Behaviour:
- Reset (synchronous, any state, including mid-operation):
  - state=IDLE; acc, mcand, mplier, product=0; ovf=0; done=0; busy=0; alu_req=0.
  - alu_a and alu_b reflect their registers, so they read 0.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - On start=1: acc<=0, mcand<=op_a, mplier<=op_b, ovf<=0; next state RUN.
  - product is not cleared until RUN completes.
- RUN (one cycle per multiplier bit):
  - alu_a=acc, alu_b=mcand, alu_control=2'b00, alu_req=1.
  - If mplier[0]=1: acc<=alu_result; ovf<=ovf|alu_flags[1].
  - ovf<=ovf|(mcand[width-1] & |mplier[width-1:1]); this catches a set bit lost by the shift while later bits still need it.
  - mcand<=mcand<<1; mplier<=mplier>>1.
  - If mplier[width-1:1]==0: next state DONE, and product<=(mplier[0] ? alu_result : acc).
- DONE: done=1 for exactly one cycle, busy=1; next state IDLE. product and ovf stay valid and stable.
- Latency:
  - RUN cycle count = index of highest set bit of op_b + 1, minimum 1 (op_b=0 gives 1).
  - done rises (RUN count + 1) cycles after the start cycle.
  - Worst case is width+1 cycles.
- start while busy (RUN or DONE): ignored, no queuing. A start in the same cycle as done is also ignored.
- Flags n, z, v from the ALU are ignored.
- Unsigned semantics only. product is always the exact low width bits of the true product, including when ovf=1.
- Outputs are registered or direct register values. There is no combinational path from start/op_a/op_b to any output.

Test Plan:
- reset, start with op_a=7, op_b=6 -> 3 RUN cycles, then done pulse 4 cycles after start; product=42, ovf=0; alu_req high exactly 3 cycles; alu_control=2'b00 throughout.
- op_a=32'h1234_5678, op_b=0 -> 1 RUN cycle; product=0, ovf=0, done 2 cycles after start. Repeat with op_a=0, op_b=32'hFFFF_FFFF -> 32 RUN cycles, product=0, ovf=0.
- op_a=32'hFFFF_FFFF, op_b=2 -> product=32'hFFFF_FFFE, ovf=1 (shift loss). Then op_a=32'h8000_0000, op_b=3 -> product=32'h8000_0000, ovf=1.
- op_a=32'hFFFF_FFFF, op_b=32'hFFFF_FFFF -> done after 33 cycles; product=32'h0000_0001, ovf=1. Then op_a=32'h0001_0000, op_b=32'h0000_FFFF -> product=32'hFFFF_0000, ovf=0.
- Pulse start again during RUN and again on the done cycle with different operands -> both ignored, first product unchanged. A start one cycle after done is accepted.
- Assert reset for one cycle mid-RUN -> next cycle state=IDLE, busy=0, alu_req=0, product=0, ovf=0, no done pulse. A following start of 3*5 gives product=15.
